// File: rtl/inst_fetch.sv
// Instruction fetch stage: streams prog_len words out of the instruction BRAM through a
// credit-limited return FIFO. Define INST_FETCH_LOOP_EN to replay the program until abort.
module inst_fetch #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned BRAM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = BRAM_LATENCY + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              stall,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [31:0]       bram_dout,
  output logic [31:0]       instruction,
  output logic              valid_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + BRAM_LATENCY + 1);

  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  OCC_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  OCC_MAX  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]   deliver_cnt_q, deliver_cnt_d;
  logic              done_d;

  logic [BRAM_LATENCY-1:0] rd_shift_q;
  logic [CNT_W-1:0]        inflight;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_count_q;
  logic              fifo_empty, fifo_full;

  logic credit_ok, issue, push, pop, last_pop, flush, in_run;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  // Reads still in the BRAM pipeline; each one owns a FIFO slot until it is delivered.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(rd_shift_q[i]);
    end
  end

  assign in_run     = (state_q == StRun);
  assign fifo_empty = (fifo_count_q == '0);
  assign fifo_full  = (fifo_count_q == OCC_MAX);
  assign credit_ok  = (inflight + fifo_count_q) < OCC_MAX;

  assign issue     = in_run && (issue_cnt_q < len_q) && credit_ok;
  assign bram_en   = issue;
  assign bram_addr = issue ? issue_cnt_q[ADDR_W-1:0] : '0;

  assign push     = in_run && rd_shift_q[BRAM_LATENCY-1];
  assign pop      = in_run && !abort && !stall && !fifo_empty;
  assign last_pop = pop && (deliver_cnt_q == len_q - CNT_ONE);

  assign busy = (state_q != StIdle);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = deliver_cnt_q;
    done_d        = 1'b0;
    flush         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (inflight == '0)) begin
          if (prog_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d       = StRun;
            len_d         = prog_len;
            issue_cnt_d   = '0;
            deliver_cnt_d = '0;
            flush         = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue) begin
`ifdef INST_FETCH_LOOP_EN
          issue_cnt_d = (issue_cnt_q == len_q - CNT_ONE) ? '0 : issue_cnt_q + CNT_ONE;
`else
          issue_cnt_d = issue_cnt_q + CNT_ONE;
`endif
        end
        if (abort) begin
          state_d = StDrain;
          flush   = 1'b1;
        end else if (pop) begin
          deliver_cnt_d = deliver_cnt_q + CNT_ONE;
          if (last_pop) begin
            done_d = 1'b1;
`ifdef INST_FETCH_LOOP_EN
            deliver_cnt_d = '0;
`else
            state_d = StIdle;
`endif
          end
        end
      end
      StDrain: begin
        if (inflight == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      len_q         <= '0;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      done          <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_shift_q <= '0;
    end else begin
      rd_shift_q[0] <= issue;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        rd_shift_q[i] <= rd_shift_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bram_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else if (flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        fifo_count_q <= fifo_count_q + OCC_ONE;
      end else if (pop && !push) begin
        fifo_count_q <= fifo_count_q - OCC_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out   <= 1'b0;
      instruction <= '0;
    end else begin
      valid_out <= pop;
      if (pop) begin
        instruction <= fifo_mem[rd_ptr_q];
      end
    end
  end

  // The credit check must make this unreachable.
  push_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule
